// File: rtl/id_stage.sv
// MIPS decode stage: combinational decode captured into a main output register
// backed by a one-entry skid register. Optional trap on illegal encodings: ID_STAGE_ILLEGAL_TRAP_EN.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [31:0] out_imm,
  output logic [31:0] out_jtarget,
  output logic [3:0]  out_alu_op,
  output logic        out_reg_write,
  output logic        out_reg_dst,
  output logic        out_alu_src,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_mem_to_reg,
  output logic        out_link,
  output logic        ct_branch,
  output logic        ct_branchn,
  output logic        ct_jump,
  output logic        out_illegal,
  output logic [31:0] decode_count
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_PASS = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] jtarget;
    alu_op_e     alu_op;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        link;
    logic        branch;
    logic        branchn;
    logic        jump;
    logic        illegal;
  } dec_t;

  dec_t        dec;
  dec_t        main_q;
  dec_t        skid_q;
  dec_t        shown;
  logic [31:0] main_pc;
  logic [31:0] skid_pc;
  logic        main_valid;
  logic        skid_valid;
  logic        known;
  logic [3:0]  pc_hi;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        accept;
  logic        drain;

  assign op     = in_inst[31:26];
  assign funct  = in_inst[5:0];
  // Top nibble of pc+4: only carries when bits [27:2] are all ones.
  assign pc_hi  = in_pc[31:28] + {3'b000, &in_pc[27:2]};
  assign accept = in_valid && !skid_valid;
  assign drain  = main_valid && out_ready;

  always_comb begin
    dec         = '0;
    known       = 1'b1;
    dec.rs      = in_inst[25:21];
    dec.rt      = in_inst[20:16];
    dec.rd      = in_inst[15:11];
    dec.shamt   = in_inst[10:6];
    dec.imm     = {{16{in_inst[15]}}, in_inst[15:0]};
    dec.jtarget = {pc_hi, in_inst[25:0], 2'b00};
    dec.alu_op  = ALU_ADD;
    case (op)
      6'h00: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (funct)
          6'h20:   dec.alu_op = ALU_ADD;
          6'h22:   dec.alu_op = ALU_SUB;
          6'h24:   dec.alu_op = ALU_AND;
          6'h25:   dec.alu_op = ALU_OR;
          6'h2A:   dec.alu_op = ALU_SLT;
          6'h00:   dec.alu_op = ALU_SLL;
          6'h02:   dec.alu_op = ALU_SRL;
          default: known = 1'b0;
        endcase
      end
      6'h08: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      6'h0C: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_AND;
        dec.imm       = {16'h0000, in_inst[15:0]};
      end
      6'h0D: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_OR;
        dec.imm       = {16'h0000, in_inst[15:0]};
      end
      6'h0F: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_PASS;
        dec.imm       = {in_inst[15:0], 16'h0000};
      end
      6'h23: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      6'h2B: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      6'h04: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      6'h05: begin
        dec.branchn = 1'b1;
        dec.alu_op  = ALU_SUB;
      end
      6'h02: dec.jump = 1'b1;
      6'h03: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.link      = 1'b1;
      end
      default: known = 1'b0;
    endcase

    if (!known) begin
      dec.alu_op     = ALU_ADD;
      dec.reg_write  = 1'b0;
      dec.reg_dst    = 1'b0;
      dec.alu_src    = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.link       = 1'b0;
      dec.branch     = 1'b0;
      dec.branchn    = 1'b0;
      dec.jump       = 1'b0;
    end
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    dec.illegal = !known;
`else
    dec.illegal = 1'b0;
`endif
  end

  // Skid is only ever filled while it is empty, so a skid move-up and a new
  // accept never coincide; ordering falls out of the priority below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (drain) begin
        main_q     <= skid_q;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || out_ready) begin
        main_q     <= dec;
        main_pc    <= in_pc;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_pc    <= in_pc;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decode_count <= '0;
    end else if (drain) begin
      decode_count <= decode_count + 32'd1;
    end
  end

  always_comb begin
    shown = '0;
    if (main_valid) begin
      shown = main_q;
    end
  end

  assign in_ready       = !skid_valid;
  assign out_valid      = main_valid;
  assign out_pc         = main_valid ? main_pc : RESET_PC;
  assign out_rs         = shown.rs;
  assign out_rt         = shown.rt;
  assign out_rd         = shown.rd;
  assign out_shamt      = shown.shamt;
  assign out_imm        = shown.imm;
  assign out_jtarget    = shown.jtarget;
  assign out_alu_op     = shown.alu_op;
  assign out_reg_write  = shown.reg_write;
  assign out_reg_dst    = shown.reg_dst;
  assign out_alu_src    = shown.alu_src;
  assign out_mem_read   = shown.mem_read;
  assign out_mem_write  = shown.mem_write;
  assign out_mem_to_reg = shown.mem_to_reg;
  assign out_link       = shown.link;
  assign ct_branch      = shown.branch;
  assign ct_branchn     = shown.branchn;
  assign ct_jump        = shown.jump;
  assign out_illegal    = shown.illegal;

endmodule
